// File: rtl/mul_share_pkg.sv
// Shared types and constants for the time-shared multiplier controller.
// The state enum, default sizes and product-width helper live here.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_WIDTH = 4;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mul_step_core.sv
// WIDTH-step shift-add multiplier: loads operands on start, then runs one
// step per cycle (multiplier LSB first); done marks the cycle of the final step.
module mul_step_core
    import mul_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     done,
    output logic [prod_w(WIDTH)-1:0] product
);

    localparam int PW    = prod_w(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;

    assign done    = r_active && (r_cnt == LAST);
    assign product = r_acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            // Zero operands still walk all WIDTH steps so latency never varies.
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (done) begin
                r_cnt    <= '0;
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin arbiter and IDLE/RUN/DONE sequencer sharing one mul_step_core.
// Optional stats ports (op_count, last_id) are built when MUL_SHARE_CTRL_STATS_EN is defined.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    a,
    input  logic [NREQ*WIDTH-1:0]    b,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [prod_w(WIDTH)-1:0] res,
    output logic                     busy
`ifdef MUL_SHARE_CTRL_STATS_EN
    ,
    output logic [15:0]              op_count,
    output logic [$clog2(NREQ)-1:0]  last_id
`endif
);

    localparam int PW    = prod_w(WIDTH);
    localparam int PTR_W = $clog2(NREQ);
    localparam logic [PTR_W:0]  NREQ_X = (PTR_W + 1)'(NREQ);
    localparam logic [NREQ-1:0] ONE    = NREQ'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_winner;
    logic [PTR_W:0]   w_idx;
    logic             w_found;
    logic             w_start;
    logic             w_core_done;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic [PW-1:0]    w_product;

    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [PW-1:0]    r_res;
    logic             r_busy;

    // Search starts one past the last winner, so a held request yields to others.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            if (w_idx >= NREQ_X) begin
                w_idx = w_idx - NREQ_X;
            end
            if (!w_found && req[w_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_a_sel = a[w_winner*WIDTH +: WIDTH];
    assign w_b_sel = b[w_winner*WIDTH +: WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_start     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_core_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_ptr       <= PTR_W'(NREQ - 1);
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_res       <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            if (w_start) begin
                r_gnt  <= ONE << w_winner;
                r_ptr  <= w_winner;
                r_busy <= 1'b1;
            end
            if (r_state == DONE) begin
                r_res       <= w_product;
                r_rsp_valid <= ONE << r_ptr;
                r_busy      <= 1'b0;
            end
        end
    end

    mul_step_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .rstn   (rstn),
        .start  (w_start),
        .a      (w_a_sel),
        .b      (w_b_sel),
        .done   (w_core_done),
        .product(w_product)
    );

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign res       = r_res;
    assign busy      = r_busy;

`ifdef MUL_SHARE_CTRL_STATS_EN
    logic [15:0]      r_op_count;
    logic [PTR_W-1:0] r_last_id;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op_count <= '0;
            r_last_id  <= '0;
        end else if (r_state == DONE) begin
            if (r_op_count != 16'hFFFF) begin
                r_op_count <= r_op_count + 16'd1;
            end
            r_last_id <= r_ptr;
        end
    end

    assign op_count = r_op_count;
    assign last_id  = r_last_id;
`endif

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl (NREQ=2, WIDTH=4) with hand-computed
// expectations; stats checks are built when MUL_SHARE_CTRL_STATS_EN is defined.
module tb_mul_share_ctrl;

    logic       clk;
    logic       rstn;
    logic [1:0] req;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] gnt;
    logic [1:0] rsp_valid;
    logic [7:0] res;
    logic       busy;
`ifdef MUL_SHARE_CTRL_STATS_EN
    logic [15:0] op_count;
    logic        last_id;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int prev_gnt_cyc;

    mul_share_ctrl #(
        .NREQ (2),
        .WIDTH(4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .a        (a),
        .b        (b),
        .gnt      (gnt),
        .rsp_valid(rsp_valid),
        .res      (res),
        .busy     (busy)
`ifdef MUL_SHARE_CTRL_STATS_EN
        ,
        .op_count (op_count),
        .last_id  (last_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after the grant edge: four quiet step cycles, then the result edge.
    task automatic wait_result(input logic [1:0] exp_rsp, input logic [7:0] exp_res);
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("rsp_early", {30'd0, rsp_valid}, 32'd0);
            chk("busy_run", {31'd0, busy}, 32'd1);
        end
        tick();
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rsp});
        chk("res", {24'd0, res}, {24'd0, exp_res});
        chk("busy_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        req  = 2'b00;
        a    = 8'h00;
        b    = 8'h00;
        tick();
        tick();
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid}, 32'd0);
        chk("rst_res", {24'd0, res}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        tick();
        chk("idle_gnt", {30'd0, gnt}, 32'd0);

        // Single request: 6*7 = 42
        req = 2'b01; a[3:0] = 4'd6; b[3:0] = 4'd7;
        tick();
        chk("gnt_single", {30'd0, gnt}, 32'd1);
        chk("busy_grant", {31'd0, busy}, 32'd1);
        req = 2'b00;
        wait_result(2'b01, 8'd42);
        tick();
        chk("no_regrant", {30'd0, gnt}, 32'd0);

        // Boundary: 15*15 = 225 on requester 1, then 0*9 = 0 on requester 0
        req = 2'b10; a[7:4] = 4'd15; b[7:4] = 4'd15;
        tick();
        chk("gnt_max", {30'd0, gnt}, 32'd2);
        req = 2'b00;
        wait_result(2'b10, 8'd225);
        req = 2'b01; a[3:0] = 4'd0; b[3:0] = 4'd9;
        tick();
        chk("gnt_zero", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        wait_result(2'b01, 8'd0);

        // Contention after a fresh reset: order 0,1,0,1, grants 6 cycles apart
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req = 2'b11; a = {4'd8, 4'd3}; b = {4'd5, 4'd3};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gnt_rr", {30'd0, gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) chk("gnt_spacing", cyc - prev_gnt_cyc, 32'd6);
            prev_gnt_cyc = cyc;
            wait_result((i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'd9 : 8'd40);
        end
        req = 2'b00;

        // Operands change and req drops after grant: result still 6*7
        req = 2'b01; a[3:0] = 4'd6; b[3:0] = 4'd7;
        tick();
        chk("gnt_chg", {30'd0, gnt}, 32'd1);
        a[3:0] = 4'd2;
        req = 2'b00;
        wait_result(2'b01, 8'd42);
        tick();
        chk("chg_no_gnt", {30'd0, gnt}, 32'd0);
        tick();
        chk("chg_idle_busy", {31'd0, busy}, 32'd0);

        // Reset two cycles into requester 1's operation
        req = 2'b10; a = {4'd8, 4'd3}; b = {4'd5, 4'd3};
        tick();
        chk("gnt_abort", {30'd0, gnt}, 32'd2);
        req = 2'b00;
        tick();
        tick();
        rstn = 1'b0;
        #1;
        chk("abort_gnt", {30'd0, gnt}, 32'd0);
        chk("abort_rsp", {30'd0, rsp_valid}, 32'd0);
        chk("abort_res", {24'd0, res}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        req = 2'b11;
        tick();
        chk("held_gnt", {30'd0, gnt}, 32'd0);
        rstn = 1'b1;
        tick();
        chk("gnt_after_rst", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        wait_result(2'b01, 8'd9);

        // Two more ops, both on requester 1: 8*5 = 40 each
        req = 2'b10;
        tick();
        chk("gnt_r1_a", {30'd0, gnt}, 32'd2);
        req = 2'b00;
        wait_result(2'b10, 8'd40);
        req = 2'b10;
        tick();
        chk("gnt_r1_b", {30'd0, gnt}, 32'd2);
        req = 2'b00;
        wait_result(2'b10, 8'd40);
`ifdef MUL_SHARE_CTRL_STATS_EN
        chk("op_count", {16'd0, op_count}, 32'd3);
        chk("last_id", {31'd0, last_id}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("op_count_rst", {16'd0, op_count}, 32'd0);
        chk("last_id_rst", {31'd0, last_id}, 32'd0);
        tick();
        rstn = 1'b1;
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Arbiter and sequencer that time-shares one sequential shift-add multiplier among NREQ requesters.
- Selects a pending requester round-robin, captures its operands, and runs the multiplier for WIDTH step cycles.
- Returns the product on a shared result bus with a one-cycle valid strobe to the served requester.
- Sits between the requesting datapaths and the multiplier core, replacing per-user restart-by-reset control with a proper request/response handshake.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- req  input  NREQ  level request, bit i from requester i.
- a  input  NREQ*WIDTH  operand A; slice i belongs to requester i.
- b  input  NREQ*WIDTH  operand B; slice i belongs to requester i.
- gnt  output  NREQ  one-hot, one-cycle pulse when requester i's operands are captured.
- rsp_valid  output  NREQ  one-hot, one-cycle pulse when res holds requester i's product.
- res  output  2*WIDTH  product, unsigned A*B.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (async, rstn=0): state=IDLE; gnt=0; rsp_valid=0; res=0; busy=0; step counter=0; round-robin pointer=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, RUN, DONE.
- IDLE: if any req bit is high at a rising edge:
  - Winner is the first set bit searching from pointer+1 upward, with wrap-around.
  - Capture that requester's a/b slices.
  - gnt[winner]=1 for one cycle; pointer=winner; busy=1; go to RUN.
- IDLE with no request: remain in IDLE, all strobes 0.
- RUN: one shift-add step per cycle, LSB of multiplier first.
  - Accumulator is 2*WIDTH bits; no overflow is possible.
  - After exactly WIDTH steps, go to DONE.
- DONE: res=product; rsp_valid[winner]=1 for one cycle; busy=0; go to IDLE.
  - res holds its value until the next DONE.
- Latency: rsp_valid rises WIDTH+1 clock edges after the edge that raised gnt. Service slot is WIDTH+2 cycles; the next grant can occur at the edge following DONE.
- Operand rules:
  - Operands are sampled only at grant.
  - Changes to a/b after grant are ignored.
  - Dropping req after grant does not cancel; the result is still delivered.
- A requester holding req high is served again only after all other pending requesters have been served (strict round-robin fairness).
- Requests arriving during RUN/DONE wait; there is no queueing beyond the req level.
- Zero operand: the full WIDTH steps still run, so latency is fixed.
- Reset mid-operation: the operation is aborted, with no rsp_valid and no gnt. Pointer returns to NREQ-1.

Optional Feature:
- Macro: MUL_SHARE_CTRL_STATS_EN.
- With the macro defined:
  - Adds output port op_count, 16 bits: a saturating count of completed operations, incremented in DONE, cleared by reset, holding at 16'hFFFF.
  - Adds output port last_id, $clog2(NREQ) bits: index of the last served requester, reset 0.
- Without the macro: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mul_share_pkg holds:
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH/NREQ constants.
  - Product-width function 2*WIDTH.
- One sub-module: mul_step_core. It is the WIDTH-step shift-add engine with start, done, a, b and product ports, instantiated once.
- Arbitration and the FSM stay in mul_share_ctrl.

Test Plan:
- Single request, WIDTH=4: req[0]=1, a0=6, b0=7 -> gnt[0] pulse, then rsp_valid[0] 5 edges later, res=42, busy high for the intervening cycles.
- Boundary operands: a=15, b=15 -> res=225. Then a=0, b=9 -> res=0 with unchanged latency.
- Contention: req=2'b11 held, a0=3 b0=3, a1=8 b1=5 -> service order 0,1,0,1 with res 9,40,9,40. Grants are spaced 6 cycles apart.
- Operand change after grant: change a0 from 6 to 2 one cycle after gnt[0] and drop req[0] -> res=42 still delivered, no further grant.
- Reset mid-RUN: assert rstn=0 two cycles after gnt[1] -> all outputs 0 immediately. With req=2'b11 after release, the first grant goes to requester 0.
- With MUL_SHARE_CTRL_STATS_EN: three completed ops -> op_count=3 and last_id equal to the last served index. Reset -> both 0.
